// File: rtl/trdb_pkg.sv
// Shared types for the trace packet serializer: FSM states, header byte layout
// and the header half of a queued packet entry.
package trdb_pkg;

  typedef enum logic [1:0] {
    SER_IDLE,
    SER_HEADER,
    SER_PAYLOAD
  } trdb_ser_state_e;

  localparam int HDR_LEN_BYTE  = 0;
  localparam int HDR_TYPE_BYTE = 1;

  // Type is stored zero-extended to a full byte so it drops straight into the header beat.
  typedef struct packed {
    logic [7:0] ptype;
    logic [7:0] len;
  } trdb_pkt_hdr_t;

endpackage

// File: rtl/trdb_packet_serializer_if.sv
// Packet-in / beat-out bus of the serializer. The serializer is the slave;
// the emitter and trace sink together form the master side.
interface trdb_packet_serializer_if #(
  parameter int PAYLOAD_BYTES = 32,
  parameter int BEAT_BYTES    = 4,
  parameter int PTYPE_W       = 2
);

  logic                       pkt_valid_i;
  logic                       pkt_ready_o;
  logic [PTYPE_W-1:0]         pkt_type_i;
  logic [7:0]                 pkt_len_i;
  logic [8*PAYLOAD_BYTES-1:0] pkt_payload_i;

  logic                       beat_valid_o;
  logic                       beat_ready_i;
  logic [8*BEAT_BYTES-1:0]    beat_data_o;
  logic [BEAT_BYTES-1:0]      beat_be_o;
  logic                       beat_last_o;

  modport master (
    output pkt_valid_i, pkt_type_i, pkt_len_i, pkt_payload_i, beat_ready_i,
    input  pkt_ready_o, beat_valid_o, beat_data_o, beat_be_o, beat_last_o
  );

  modport slave (
    input  pkt_valid_i, pkt_type_i, pkt_len_i, pkt_payload_i, beat_ready_i,
    output pkt_ready_o, beat_valid_o, beat_data_o, beat_be_o, beat_last_o
  );

endinterface

// File: rtl/trdb_pkt_fifo.sv
// Synchronous ring FIFO of packet entries with a flush that can keep the head
// entry (the packet currently being streamed out).
module trdb_pkt_fifo #(
  parameter type  entry_t = logic [7:0],
  parameter int   DEPTH   = 4,
  localparam int  AW      = $clog2(DEPTH),
  localparam int  LW      = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  entry_t        push_data_i,
  output logic          push_ok_o,
  input  logic          pop_i,
  input  logic          flush_i,
  input  logic          flush_keep_head_i,
  output entry_t        head_o,
  output logic [LW-1:0] level_o,
  output logic          empty_next_o,
  output logic          full_next_o
);

  entry_t        mem [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] wr_addr;
  logic [LW-1:0] level_q, level_d;
  logic [LW-1:0] level_base;
  logic          do_push;
  logic          do_pop;

  // Flush is resolved first so a same-cycle push lands in the emptied queue.
  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_addr    = wr_ptr_q;
    level_base = level_q;
    if (flush_i) begin
      wr_addr    = rd_ptr_q + AW'(flush_keep_head_i);
      level_base = LW'(flush_keep_head_i);
    end
    do_pop    = pop_i && (level_base != '0);
    push_ok_o = (level_base < LW'(DEPTH)) || do_pop;
    do_push   = push_i && push_ok_o;
    level_d   = level_base;
    wr_ptr_d  = wr_addr;
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      level_d  = level_d - LW'(1);
    end
    if (do_push) begin
      wr_ptr_d = wr_addr + AW'(1);
      level_d  = level_d + LW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem[wr_addr] <= push_data_i;
    end
  end

  assign head_o       = mem[rd_ptr_q];
  assign level_o      = level_q;
  assign empty_next_o = (level_d == '0);
  assign full_next_o  = (level_d == LW'(DEPTH));

endmodule

// File: rtl/trdb_packet_serializer.sv
// Queues whole trace packets and streams each one as a header beat followed by
// little-endian payload beats; packets that do not fit are dropped and counted.
module trdb_packet_serializer
  import trdb_pkg::*;
#(
  parameter int  PAYLOAD_BYTES = 32,
  parameter int  BEAT_BYTES    = 4,
  parameter int  FIFO_DEPTH    = 4,
  parameter int  PTYPE_W       = 2,
  localparam int LVL_W         = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  trdb_packet_serializer_if.slave  bus,
  input  logic                     flush_i,
  output logic [LVL_W-1:0]         fifo_level_o,
  output logic [15:0]              drop_cnt_o,
  output logic                     overflow_o
);

  localparam int BEAT_W = 8 * BEAT_BYTES;
  localparam int OFF_W  = 9;

  typedef struct packed {
    trdb_pkt_hdr_t              hdr;
    logic [8*PAYLOAD_BYTES-1:0] payload;
  } entry_t;

  trdb_ser_state_e   state_q, state_d;
  logic [OFF_W-1:0]  offset_q, offset_d;
  logic [15:0]       drop_cnt_q, drop_cnt_d;
  logic              overflow_q, overflow_d;
  logic              pkt_ready_q, pkt_ready_d;

  entry_t            push_entry;
  entry_t            head;
  logic              len_bad;
  logic              pkt_drop;
  logic              fifo_push_ok;
  logic              fifo_empty_next;
  logic              fifo_full_next;
  logic [LVL_W-1:0]  fifo_level;

  logic              beat_valid;
  logic [BEAT_W-1:0] beat_data;
  logic [BEAT_BYTES-1:0] beat_be;
  logic              beat_last;
  logic              beat_hs;
  logic              in_flight;

  logic [BEAT_W-1:0]     hdr_data;
  logic [BEAT_W-1:0]     pay_win;
  logic [BEAT_W-1:0]     pay_data;
  logic [BEAT_BYTES-1:0] pay_be;
  logic                  pay_last;

  always_comb begin
    push_entry           = '0;
    push_entry.hdr.ptype = 8'(bus.pkt_type_i);
    push_entry.hdr.len   = bus.pkt_len_i;
    push_entry.payload   = bus.pkt_payload_i;
  end

  assign len_bad  = bus.pkt_len_i > 8'(PAYLOAD_BYTES);
  assign pkt_drop = bus.pkt_valid_i && (len_bad || !fifo_push_ok);

  // Once the header has been accepted the packet belongs to the sink, so a
  // flush must leave it in place until its last beat pops it.
  assign beat_hs   = beat_valid && bus.beat_ready_i;
  assign in_flight = (state_q == SER_PAYLOAD) || ((state_q == SER_HEADER) && beat_hs);

  trdb_pkt_fifo #(
    .entry_t (entry_t),
    .DEPTH   (FIFO_DEPTH)
  ) u_fifo (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .push_i            (bus.pkt_valid_i && !len_bad),
    .push_data_i       (push_entry),
    .push_ok_o         (fifo_push_ok),
    .pop_i             (beat_hs && beat_last),
    .flush_i           (flush_i),
    .flush_keep_head_i (in_flight),
    .head_o            (head),
    .level_o           (fifo_level),
    .empty_next_o      (fifo_empty_next),
    .full_next_o       (fifo_full_next)
  );

  always_comb begin
    hdr_data                         = '0;
    hdr_data[8*HDR_LEN_BYTE +: 8]    = head.hdr.len;
    hdr_data[8*HDR_TYPE_BYTE +: 8]   = head.hdr.ptype;
  end

  // Window of the payload starting at the current byte offset; lanes past the
  // packet length are masked to zero.
  assign pay_win  = BEAT_W'({{BEAT_W{1'b0}}, head.payload} >> {offset_q, 3'b000});
  assign pay_last = (16'(offset_q) + 16'(BEAT_BYTES)) >= 16'(head.hdr.len);

  generate
    for (genvar gi = 0; gi < BEAT_BYTES; gi++) begin : g_lane
      assign pay_be[gi]          = (16'(offset_q) + 16'(gi)) < 16'(head.hdr.len);
      assign pay_data[8*gi +: 8] = pay_be[gi] ? pay_win[8*gi +: 8] : 8'h00;
    end
  endgenerate

  always_comb begin
    beat_valid = 1'b0;
    beat_data  = '0;
    beat_be    = '0;
    beat_last  = 1'b0;
    case (state_q)
      SER_HEADER: begin
        beat_valid = 1'b1;
        beat_data  = hdr_data;
        beat_be    = '1;
        beat_last  = (head.hdr.len == 8'd0);
      end
      SER_PAYLOAD: begin
        beat_valid = 1'b1;
        beat_data  = pay_data;
        beat_be    = pay_be;
        beat_last  = pay_last;
      end
      default: ;
    endcase
  end

  // Whenever a packet finishes (or a flush empties the queue) the next state
  // follows the post-edge occupancy, so back-to-back packets have no gap.
  always_comb begin
    state_d  = state_q;
    offset_d = offset_q;
    case (state_q)
      SER_IDLE: begin
        if (!fifo_empty_next) state_d = SER_HEADER;
      end
      SER_HEADER: begin
        if (beat_hs && (head.hdr.len != 8'd0)) begin
          state_d  = SER_PAYLOAD;
          offset_d = '0;
        end else if (beat_hs || flush_i) begin
          state_d = fifo_empty_next ? SER_IDLE : SER_HEADER;
        end
      end
      SER_PAYLOAD: begin
        if (beat_hs) begin
          if (beat_last) begin
            offset_d = '0;
            state_d  = fifo_empty_next ? SER_IDLE : SER_HEADER;
          end else begin
            offset_d = offset_q + OFF_W'(BEAT_BYTES);
          end
        end
      end
      default: state_d = SER_IDLE;
    endcase
  end

  always_comb begin
    drop_cnt_d  = flush_i ? 16'd0 : drop_cnt_q;
    overflow_d  = flush_i ? 1'b0 : overflow_q;
    pkt_ready_d = !fifo_full_next;
    if (pkt_drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_d != 16'hFFFF) drop_cnt_d = drop_cnt_d + 16'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= SER_IDLE;
      offset_q    <= '0;
      drop_cnt_q  <= '0;
      overflow_q  <= 1'b0;
      pkt_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      offset_q    <= offset_d;
      drop_cnt_q  <= drop_cnt_d;
      overflow_q  <= overflow_d;
      pkt_ready_q <= pkt_ready_d;
    end
  end

  assign bus.pkt_ready_o  = pkt_ready_q;
  assign bus.beat_valid_o = beat_valid;
  assign bus.beat_data_o  = beat_data;
  assign bus.beat_be_o    = beat_be;
  assign bus.beat_last_o  = beat_last;
  assign fifo_level_o     = fifo_level;
  assign drop_cnt_o       = drop_cnt_q;
  assign overflow_o       = overflow_q;

endmodule

// File: tb/tb_trdb_packet_serializer.sv
// Directed + randomized bench for trdb_packet_serializer; a packet-queue model
// predicts every output each cycle.
module tb_trdb_packet_serializer;

  localparam int PB = 32;
  localparam int BB = 4;
  localparam int FD = 4;
  localparam int PW = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [2:0]  fifo_level;
  logic [15:0] drop_cnt;
  logic        overflow;

  trdb_packet_serializer_if #(.PAYLOAD_BYTES(PB), .BEAT_BYTES(BB), .PTYPE_W(PW)) bus ();

  trdb_packet_serializer #(
    .PAYLOAD_BYTES (PB),
    .BEAT_BYTES    (BB),
    .FIFO_DEPTH    (FD),
    .PTYPE_W       (PW)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .bus          (bus),
    .flush_i      (flush),
    .fifo_level_o (fifo_level),
    .drop_cnt_o   (drop_cnt),
    .overflow_o   (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] t;
    logic [7:0] len;
    logic [7:0] pay [PB];
  } pkt_t;

  pkt_t mq[$];
  int   bidx    = 0;
  int   m_drops = 0;
  bit   m_ovf   = 1'b0;
  int   checks  = 0;
  int   errors  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Beat 0 is the header; beat i>0 carries payload bytes (i-1)*BB onward.
  function automatic void exp_beat(input pkt_t p, input int idx,
                                   output logic [31:0] d, output logic [3:0] be, output logic last);
    int nb;
    nb   = (int'(p.len) + BB - 1) / BB;
    d    = '0;
    be   = '0;
    last = 1'b0;
    if (idx == 0) begin
      d[7:0]  = p.len;
      d[15:8] = {6'b0, p.t};
      be      = 4'hF;
      last    = (p.len == 8'd0);
    end else begin
      for (int k = 0; k < BB; k++) begin
        int b;
        b = (idx - 1) * BB + k;
        if (b < int'(p.len)) begin
          d[8*k +: 8] = p.pay[b];
          be[k]       = 1'b1;
        end
      end
      last = (idx == nb);
    end
  endfunction

  function automatic bit cur_last();
    logic [31:0] d;
    logic [3:0]  be;
    logic        l;
    if (mq.size() == 0) return 1'b0;
    exp_beat(mq[0], bidx, d, be, l);
    return l;
  endfunction

  task automatic check_now();
    logic [31:0] d;
    logic [3:0]  be;
    logic        last;
    d = '0; be = '0; last = 1'b0;
    if (mq.size() > 0) exp_beat(mq[0], bidx, d, be, last);
    chk("beat_valid", 32'(bus.beat_valid_o), 32'(mq.size() > 0));
    chk("beat_data",  bus.beat_data_o, d);
    chk("beat_be",    32'(bus.beat_be_o), 32'(be));
    chk("beat_last",  32'(bus.beat_last_o), 32'(last));
    chk("fifo_level", 32'(fifo_level), 32'(mq.size()));
    chk("drop_cnt",   32'(drop_cnt), 32'(m_drops));
    chk("overflow",   32'(overflow), 32'(m_ovf));
    chk("pkt_ready",  32'(bus.pkt_ready_o), 32'(mq.size() < FD));
  endtask

  task automatic check_reset_zero();
    chk("rst_valid", 32'(bus.beat_valid_o), 32'd0);
    chk("rst_data",  bus.beat_data_o, 32'd0);
    chk("rst_be",    32'(bus.beat_be_o), 32'd0);
    chk("rst_last",  32'(bus.beat_last_o), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_drop",  32'(drop_cnt), 32'd0);
    chk("rst_ovf",   32'(overflow), 32'd0);
    chk("rst_ready", 32'(bus.pkt_ready_o), 32'd0);
  endtask

  // One clock: check this cycle's outputs, drive inputs, advance the model.
  task automatic step(input bit v, input logic [1:0] t, input int len,
                      input bit rdy, input bit fl, input bit seq);
    pkt_t             p;
    logic [8*PB-1:0]  vec;
    logic [31:0]      d;
    logic [3:0]       be;
    logic             last;
    bit               hs;
    @(negedge clk);
    check_now();
    p.t   = t;
    p.len = 8'(len);
    for (int k = 0; k < PB; k++) begin
      p.pay[k]      = seq ? 8'(k + 1) : 8'($urandom);
      vec[8*k +: 8] = p.pay[k];
    end
    bus.pkt_valid_i   = v;
    bus.pkt_type_i    = t;
    bus.pkt_len_i     = 8'(len);
    bus.pkt_payload_i = vec;
    bus.beat_ready_i  = rdy;
    flush             = fl;

    hs = rdy && (mq.size() > 0);
    last = 1'b0;
    if (mq.size() > 0) exp_beat(mq[0], bidx, d, be, last);
    if (fl) begin
      m_drops = 0;
      m_ovf   = 1'b0;
      if (mq.size() > 0 && (bidx > 0 || hs)) begin
        while (mq.size() > 1) void'(mq.pop_back());
      end else begin
        mq.delete();
        bidx = 0;
      end
    end
    if (hs) begin
      if (last) begin
        void'(mq.pop_front());
        bidx = 0;
      end else begin
        bidx++;
      end
    end
    if (v) begin
      if (len > PB || mq.size() >= FD) begin
        if (m_drops != 16'hFFFF) m_drops++;
        m_ovf = 1'b1;
      end else begin
        mq.push_back(p);
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && mq.size() > 0; i++) step(0, 2'd0, 0, 1, 0, 0);
    step(0, 2'd0, 0, 1, 0, 0);
    chk("drained_level", 32'(fifo_level), 32'd0);
  endtask

  initial begin
    bit found;
    bus.pkt_valid_i   = 1'b0;
    bus.pkt_type_i    = '0;
    bus.pkt_len_i     = '0;
    bus.pkt_payload_i = '0;
    bus.beat_ready_i  = 1'b0;

    repeat (3) @(negedge clk);
    check_reset_zero();
    rst = 1'b0;

    // Directed len=6 packet, then a zero-length packet.
    step(1, 2'd2, 6, 1, 0, 1);
    repeat (4) step(0, 2'd0, 0, 1, 0, 0);
    step(1, 2'd1, 0, 1, 0, 0);
    repeat (3) step(0, 2'd0, 0, 1, 0, 0);

    // Stalled sink: six pushes into a four-deep queue.
    for (int i = 0; i < 20; i++) step(i < 6, 2'($urandom), int'($urandom_range(1, PB)), 0, 0, 0);
    chk("stall_level", 32'(fifo_level), 32'd4);
    chk("stall_drops", 32'(drop_cnt), 32'd2);
    chk("stall_ovf",   32'(overflow), 32'd1);

    // Push into a full queue in the same cycle as a last-beat handshake.
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (cur_last()) begin
        step(1, 2'd3, int'($urandom_range(0, PB)), 1, 0, 0);
        found = 1'b1;
      end else begin
        step(0, 2'd0, 0, 1, 0, 0);
      end
    end
    chk("last_push_seen", 32'(found), 32'd1);
    step(0, 2'd0, 0, 0, 0, 0);
    chk("full_swap_level", 32'(fifo_level), 32'd4);
    chk("full_swap_drops", 32'(drop_cnt), 32'd2);
    drain();

    // Flush mid-payload with three packets queued behind the in-flight one.
    for (int i = 0; i < 4; i++) step(1, 2'($urandom), int'($urandom_range(9, PB)), 0, 0, 0);
    step(0, 2'd0, 0, 1, 0, 0);
    step(0, 2'd0, 0, 1, 0, 0);
    step(0, 2'd0, 0, 1, 1, 0);
    step(0, 2'd0, 0, 0, 0, 0);
    chk("flush_level", 32'(fifo_level), 32'd1);
    chk("flush_drops", 32'(drop_cnt), 32'd0);
    chk("flush_ovf",   32'(overflow), 32'd0);
    drain();

    // Randomized traffic including oversize packets, stalls and flushes.
    for (int i = 0; i < 250; i++) begin
      step($urandom_range(0, 99) < 45, 2'($urandom), int'($urandom_range(0, 40)),
           $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 4, 0);
    end
    drain();

    // Asynchronous reset in the middle of a payload.
    step(1, 2'd2, 20, 1, 0, 0);
    step(0, 2'd0, 0, 1, 0, 0);
    step(0, 2'd0, 0, 1, 0, 0);
    #2 rst = 1'b1;
    #1 check_reset_zero();
    mq.delete();
    bidx    = 0;
    m_drops = 0;
    m_ovf   = 1'b0;
    bus.pkt_valid_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    step(1, 2'd1, 5, 1, 0, 0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
